// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: widths, PC step and FSM state encoding.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_settle_counter.sv
// Counts clock edges while the instruction memory output settles; flags the capture edge.
module fetch_settle_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [3:0] TERM_CNT = 4'(WAIT_CYCLES - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
    end else if (i_clear) begin
      r_cnt <= 4'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_terminal = i_en && (r_cnt == TERM_CNT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: owns the PC, waits for memory to settle, presents words to
// decode over valid/ready, follows branch redirects and halts at the end of the program.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [63:0] MEM_LIMIT   = 64'h60,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Data,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               Done,
  output logic               Fault,
  output logic [COUNT_W-1:0] FetchCount
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state, w_state_d;
  logic [ADDR_W-1:0]  r_addr, w_addr_d;
  logic [INSTR_W-1:0] r_instr, w_instr_d;
  logic [ADDR_W-1:0]  r_pc, w_pc_d;
  logic               r_valid, w_valid_d;
  logic               r_done, w_done_d;
  logic               r_fault, w_fault_d;
  logic [COUNT_W-1:0] r_count, w_count_d;

  logic              w_settled;
  logic              w_handshake;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_cnt_clear;

  assign w_handshake   = r_valid && InstrReady;
  assign w_pc_next     = r_addr + PC_STEP;
  assign w_redirect_pc = align_pc(RedirectPC);
  // Counter only runs in WAIT; leaving WAIT for any reason restarts it from zero.
  assign w_cnt_clear   = Redirect || (r_state != ST_WAIT) || w_settled;

  fetch_settle_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_settle (
    .i_clk      (CLK),
    .i_rst      (Reset),
    .i_clear    (w_cnt_clear),
    .i_en       (r_state == ST_WAIT),
    .o_terminal (w_settled)
  );

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_instr_d = r_instr;
    w_pc_d    = r_pc;
    w_valid_d = r_valid;
    w_done_d  = r_done;
    w_fault_d = r_fault;
    w_count_d = r_count;

    // A handshake counts even when a redirect in the same cycle discards its PC+4.
    if (w_handshake && (r_count != '1)) begin
      w_count_d = r_count + COUNT_ONE;
    end

    if (Redirect) begin
      w_addr_d  = w_redirect_pc;
      w_valid_d = 1'b0;
      if (RedirectPC[1:0] != 2'b00) begin
        w_fault_d = 1'b1;
      end
      if (w_redirect_pc >= MEM_LIMIT) begin
        w_state_d = ST_DONE;
        w_done_d  = 1'b1;
      end else begin
        w_state_d = ST_WAIT;
        w_done_d  = 1'b0;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_settled) begin
            w_instr_d = Data;
            w_pc_d    = r_addr;
            w_valid_d = 1'b1;
            w_state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            w_valid_d = 1'b0;
            w_addr_d  = w_pc_next;
            if (w_pc_next >= MEM_LIMIT) begin
              w_state_d = ST_DONE;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          w_valid_d = 1'b0;
        end
        default: begin
          w_valid_d = 1'b0;
          w_state_d = ST_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_WAIT;
      r_addr  <= RESET_PC;
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_instr <= w_instr_d;
      r_pc    <= w_pc_d;
      r_valid <= w_valid_d;
      r_done  <= w_done_d;
      r_fault <= w_fault_d;
      r_count <= w_count_d;
    end
  end

  assign Address    = r_addr;
  assign InstrOut   = r_instr;
  assign InstrPC    = r_pc;
  assign InstrValid = r_valid;
  assign Done       = r_done;
  assign Fault      = r_fault;
  assign FetchCount = r_count;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter, drives the 64-bit byte address to the combinational instruction memory, and waits a fixed settle time matching the memory's read delay. It then captures the 32-bit instruction word and hands it to decode over a valid/ready handshake. It also accepts branch redirects from execute, and stops at a configured end-of-program address.

Parameters:
RESET_PC, 64'h0, address fetched first after reset
WAIT_CYCLES, 2, clock edges from address change to data capture; legal range 1..15
MEM_LIMIT, 64'h60, first byte address outside the program; fetch stops here
COUNT_W, 32, width of the fetch counter

Ports:
CLK  in  1  clock; all state changes on the rising edge
Reset  in  1  asynchronous, active-high reset
Address  out  64  byte address to instruction memory (registered)
Data  in  32  instruction word from instruction memory
InstrOut  out  32  captured instruction to decode
InstrPC  out  64  address InstrOut was fetched from
InstrValid  out  1  InstrOut/InstrPC valid
InstrReady  in  1  decode accepts the instruction this cycle
Redirect  in  1  one-cycle pulse from execute: taken branch
RedirectPC  in  64  branch target; valid when Redirect=1
Done  out  1  PC reached MEM_LIMIT; fetch halted
Fault  out  1  sticky: a misaligned redirect target was received
FetchCount  out  COUNT_W  number of completed handshakes, saturating

Behaviour:
- Reset is asynchronous and active-high; CLK is the only clock.
- Reset values: Address=RESET_PC, InstrOut=0, InstrPC=0, InstrValid=0, Done=0, Fault=0, FetchCount=0, state=WAIT, cnt=0.
- States: WAIT (settling), HOLD (instruction presented), DONE (halted).
- WAIT:
  - cnt increments on each edge.
  - On the edge where cnt==WAIT_CYCLES-1: capture Data into InstrOut and Address into InstrPC, set InstrValid=1, go to HOLD.
  - InstrValid therefore rises exactly WAIT_CYCLES edges after Address changes.
- HOLD:
  - InstrOut, InstrPC and InstrValid are held stable while InstrReady=0.
  - On InstrValid&&InstrReady: FetchCount increments, saturating at all-ones; InstrValid drops.
  - After the handshake, Address becomes Address+4 and the state goes to WAIT with cnt=0.
  - If Address+4 >= MEM_LIMIT, go to DONE instead, with Done=1; Address still becomes Address+4.
- DONE: InstrValid=0; no further fetches. Only Redirect or Reset leaves DONE.
- Redirect (any state, highest priority over a handshake in the same cycle):
  - Address becomes {RedirectPC[63:2],2'b00}; InstrValid=0; cnt=0; Done=0; state goes to WAIT.
  - A handshake coinciding with Redirect still counts in FetchCount, but its PC+4 is discarded.
  - If the target is >= MEM_LIMIT, go straight to DONE instead of WAIT.
- Misalignment: if RedirectPC[1:0]!=0 on a redirect, Fault is set to 1 and stays set until Reset; the fetch proceeds from the aligned address.
- Arithmetic:
  - PC increment is modulo 2^64.
  - MEM_LIMIT comparison is unsigned.
  - Data is never inspected, so X words from unmapped memory pass through untouched.
- Reset mid-WAIT or mid-HOLD abandons the in-flight fetch immediately, without waiting for an edge; FetchCount clears.
- Address only changes on the handshake or redirect edges described above. It is stable throughout WAIT, so captured data is always settled.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_WAIT=2'd0, ST_HOLD=2'd1, ST_DONE=2'd2.
  - INSTR_W=32, ADDR_W=64, PC_STEP=4.
- One natural sub-module, fetch_settle_counter: a cnt register with clear and a terminal flag parameterised by WAIT_CYCLES. The FSM, PC and output registers stay in the top module.

Test Plan:
- Reset, InstrReady=1, memory loaded with the standard test program:
  - Address=0; InstrValid rises 2 edges later with InstrOut=F84003E9, InstrPC=0.
  - The next instruction, F84083EA at 0x4, follows 3 edges after that.
- Backpressure: hold InstrReady=0 for 5 cycles at PC 0x14:
  - InstrOut=AA0B014A is held stable, Address stays 0x14, FetchCount unchanged.
  - On release, Address=0x18 and the next InstrOut=8A0A018C.
- Redirect=1, RedirectPC=0x20 on the same edge as a handshake at 0x28:
  - Address=0x20 (not 0x2C); InstrOut=8B0901AD with InstrPC=0x20 after 2 edges.
  - FetchCount incremented by 1.
- Misaligned redirect, RedirectPC=0x26:
  - Address=0x24, Fault=1 and sticky; InstrOut=CB09018C.
- Run to end with MEM_LIMIT=0x60:
  - After the handshake at 0x5C (F80003ED), Done=1, InstrValid stays 0, FetchCount=24.
  - A Redirect to 0x0 clears Done and refetches F84003E9.
- Reset asserted asynchronously mid-WAIT at PC 0x40:
  - Outputs return to reset values before the next edge; fetch restarts at 0x0.
